// File: rtl/key_led_ctrl.sv
// Multi-channel key-to-LED controller: synchronise and debounce active-low keys,
// cycle each LED through OFF/ON/SLOW/FAST on every accepted press.
module key_led_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [WIDTH-1:0]     key,
  output logic [WIDTH-1:0]     led,
  output logic [WIDTH-1:0]     key_press,
  output logic [2*WIDTH-1:0]   mode
);

  localparam int unsigned DCNT_W = $clog2(DEB_CYCLES);
  localparam int unsigned PRE_N  = BLINK_HALF / 4;
  localparam int unsigned PRE_W  = (PRE_N > 1) ? $clog2(PRE_N) : 1;

  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRE_N - 1);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  logic [WIDTH-1:0]             sync1_q, sync2_q;
  logic [WIDTH-1:0]             stable_q, stable_d;
  logic [WIDTH-1:0][DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH-1:0]             press_q, press_d;
  logic [WIDTH-1:0][1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]             led_q, led_d;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic             fast_q, fast_d;
  logic             slow_q, slow_d;
  logic             tick_c;

  // Shared prescaler: all blinking channels stay in phase.
  always_comb begin
    tick_c = (pre_q == PRE_MAX);
    pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    tcnt_d = tcnt_q + {1'b0, tick_c};
    fast_d = fast_q ^ tick_c;
    slow_d = slow_q ^ (tick_c && (tcnt_q == 2'd3));
  end

  // Per-channel debounce, press detection, mode step and LED select.
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = dcnt_q;
    press_d  = '0;
    mode_d   = mode_q;
    led_d    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DCNT_MAX) begin
        stable_d[i] = sync2_q[i];
        dcnt_d[i]   = '0;
        if (!sync2_q[i]) begin
          press_d[i] = 1'b1;
          mode_d[i]  = mode_q[i] + 2'd1;
        end
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
      end

      case (mode_q[i])
        MODE_OFF:  led_d[i] = 1'b0;
        MODE_ON:   led_d[i] = 1'b1;
        MODE_SLOW: led_d[i] = slow_q;
        MODE_FAST: led_d[i] = fast_q;
        default:   led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      dcnt_q   <= '0;
      press_q  <= '0;
      mode_q   <= {WIDTH{MODE_ON}};
      led_q    <= '1;
      pre_q    <= '0;
      tcnt_q   <= '0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      press_q  <= press_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      pre_q    <= pre_d;
      tcnt_q   <= tcnt_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
    end
  end

  assign led       = led_q;
  assign key_press = press_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl (WIDTH=2, DEB_CYCLES=4, BLINK_HALF=8) with a
// press scoreboard and a reference model of the shared blink phases.
module tb_key_led_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key;
  logic [1:0] led;
  logic [1:0] key_press;
  logic [3:0] mode;

  key_led_ctrl #(
    .WIDTH      (2),
    .DEB_CYCLES (4),
    .BLINK_HALF (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key       (key),
    .led       (led),
    .key_press (key_press),
    .mode      (mode)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         cyc;
    logic [1:0] press;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         nrel     = 0;
  logic [3:0] exp_mode;

  // Edge counter and edges-since-reset counter (blink phase reference).
  always @(posedge sys_clk) begin
    cyc  <= cyc + 1;
    nrel <= sys_rst ? 0 : nrel + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // LED registered at edge n reflects mode and phases after edge n-1.
  function automatic logic [1:0] exp_led_f(input logic [3:0] m, input int n);
    logic [1:0] r;
    logic       fast_ph, slow_ph;
    fast_ph = (((n - 1) / 2) % 2) == 1;
    slow_ph = (((n - 1) / 8) % 2) == 1;
    for (int i = 0; i < 2; i++) begin
      case (m[2*i +: 2])
        2'b00:   r[i] = 1'b0;
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = slow_ph;
        default: r[i] = fast_ph;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: every observed press must match the oldest expectation.
  always @(negedge sys_clk) begin
    exp_t item;
    if (key_press !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_press", 32'(key_press), 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("press_val", 32'(key_press), 32'(item.press));
        check("press_cycle", 32'(cyc), 32'(item.cyc));
      end
    end
  end

  task automatic do_reset(input logic [1:0] k_during);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    key     = k_during;
    repeat (3) @(negedge sys_clk);
    check("rst_led", 32'(led), 32'h3);
    check("rst_mode", 32'(mode), 32'h5);
    check("rst_press", 32'(key_press), 32'h0);
    sys_rst  = 1'b0;
    key      = 2'b11;
    exp_mode = 4'b0101;
  endtask

  task automatic check_led(input string tag, input int ncyc);
    repeat (ncyc) begin
      @(negedge sys_clk);
      check(tag, 32'(led), 32'(exp_led_f(exp_mode, nrel)));
    end
  endtask

  // Hold keys in mask low for 'hold' cycles, then release and let it settle.
  task automatic press(input logic [1:0] mask, input int hold);
    logic [3:0] old_mode, new_mode;
    int         jmax;
    old_mode = exp_mode;
    new_mode = exp_mode;
    for (int i = 0; i < 2; i++)
      if (mask[i]) new_mode[2*i +: 2] = old_mode[2*i +: 2] + 2'd1;
    key = ~mask;
    exp_q.push_back('{cyc: cyc + 6, press: mask});
    jmax = (hold + 6 > 7) ? hold + 6 : 7;
    for (int j = 1; j <= jmax; j++) begin
      @(negedge sys_clk);
      if (j == hold) key = 2'b11;
      if (j == 5) check("mode_before", 32'(mode), 32'(old_mode));
      if (j == 6) begin
        exp_mode = new_mode;
        check("mode_after", 32'(mode), 32'(new_mode));
      end
      if (j == 7) check("led_first", 32'(led), 32'(exp_led_f(exp_mode, nrel)));
    end
  endtask

  initial begin
    sys_rst  = 1'b1;
    key      = 2'b00;
    exp_mode = 4'b0101;

    // Reset with keys held low, then idle keys high: nothing may change.
    do_reset(2'b00);
    check_led("idle_led", 20);
    check("idle_mode", 32'(mode), 32'h5);

    // Clean press on channel 0 into SLOW; channel 1 stays ON.
    do_reset(2'b11);
    press(2'b01, 8);
    check("ch1_mode", 32'(mode[3:2]), 32'h1);
    check_led("slow_led", 20);

    // Minimum accepted press width: exactly DEB_CYCLES low samples.
    press(2'b01, 4);
    check_led("fast_led_min", 8);

    // Bounce: 3 low, 1 high, 3 low never reaches the threshold.
    do_reset(2'b11);
    key = 2'b10;
    repeat (3) @(negedge sys_clk);
    key = 2'b11;
    @(negedge sys_clk);
    key = 2'b10;
    repeat (3) @(negedge sys_clk);
    key = 2'b11;
    repeat (10) @(negedge sys_clk);
    check("bounce_mode", 32'(mode), 32'h5);
    check_led("bounce_led", 4);

    // Mode wrap on channel 1: SLOW, FAST, OFF, ON.
    do_reset(2'b11);
    for (int p = 0; p < 4; p++) begin
      press(2'b10, 8);
      check_led("wrap_led", 12);
    end
    check("wrap_mode", 32'(mode), 32'h5);

    // Simultaneous press on both channels.
    do_reset(2'b11);
    press(2'b11, 8);
    check("simul_mode", 32'(mode), 32'hA);
    check_led("simul_led", 16);

    // Reset while channel 0 debounce counter sits at its maximum.
    do_reset(2'b11);
    key = 2'b10;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("midrst_mode", 32'(mode), 32'h5);
    check("midrst_press", 32'(key_press), 32'h0);
    sys_rst = 1'b0;
    exp_q.push_back('{cyc: cyc + 6, press: 2'b01});
    repeat (5) @(negedge sys_clk);
    check("midrst_pre", 32'(mode), 32'h5);
    @(negedge sys_clk);
    exp_mode = 4'b0110;
    check("midrst_post", 32'(mode), 32'h6);
    // Held key must not generate further presses.
    check_led("held_led", 20);
    key = 2'b11;
    repeat (8) @(negedge sys_clk);
    check("held_mode", 32'(mode), 32'h6);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
